// File: rtl/and_truth_table_sequencer.sv
// Stimulus/check stage for a two-input AND gate: walks {a,b} through 00,01,10,11,
// holds each vector HOLD_CYCLES clocks, samples c_in and tallies mismatches.
module and_truth_table_sequencer #(
  parameter int unsigned HOLD_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       c_in,
  output logic       a_out,
  output logic       b_out,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [3:0] result,
  output logic [2:0] err_count
);

  typedef enum logic [1:0] {StIdle, StApply, StDone} state_e;

  localparam logic [7:0] HoldLast = 8'(HOLD_CYCLES - 1);

  state_e      state_q, state_d;
  logic [1:0]  vec_q, vec_d;
  logic [7:0]  hold_q, hold_d;
  logic        a_q, a_d, b_q, b_d;
  logic        busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic [3:0]  result_q, result_d;
  logic [2:0]  err_q, err_d;

  logic        mismatch;
  logic [2:0]  err_inc;
  logic [1:0]  vec_next;

  assign mismatch = c_in != (vec_q[1] & vec_q[0]);
  assign err_inc  = err_q + {2'b00, mismatch};
  assign vec_next = vec_q + 2'd1;

  always_comb begin
    state_d  = state_q;
    vec_d    = vec_q;
    hold_d   = hold_q;
    a_d      = a_q;
    b_d      = b_q;
    busy_d   = busy_q;
    done_d   = done_q;
    pass_d   = pass_q;
    result_d = result_q;
    err_d    = err_q;
    case (state_q)
      StIdle, StDone: begin
        // A start from DONE restarts exactly like one from IDLE.
        if (start) begin
          state_d  = StApply;
          busy_d   = 1'b1;
          done_d   = 1'b0;
          pass_d   = 1'b0;
          vec_d    = 2'd0;
          hold_d   = 8'd0;
          a_d      = 1'b0;
          b_d      = 1'b0;
          result_d = 4'b0000;
          err_d    = 3'd0;
        end
      end
      StApply: begin
        if (hold_q == HoldLast) begin
          hold_d           = 8'd0;
          result_d[vec_q]  = c_in;
          err_d            = err_inc;
          if (vec_q != 2'd3) begin
            vec_d = vec_next;
            a_d   = vec_next[1];
            b_d   = vec_next[0];
          end else begin
            state_d = StDone;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_inc == 3'd0);
            a_d     = 1'b0;
            b_d     = 1'b0;
          end
        end else begin
          hold_d = hold_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      vec_q    <= 2'd0;
      hold_q   <= 8'd0;
      a_q      <= 1'b0;
      b_q      <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
      result_q <= 4'b0000;
      err_q    <= 3'd0;
    end else begin
      state_q  <= state_d;
      vec_q    <= vec_d;
      hold_q   <= hold_d;
      a_q      <= a_d;
      b_q      <= b_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
      result_q <= result_d;
      err_q    <= err_d;
    end
  end

  assign a_out     = a_q;
  assign b_out     = b_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign result    = result_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_and_truth_table_sequencer.sv
// Bench for and_truth_table_sequencer: the gate under test is a truth table the bench
// chooses per run; expectations come from that table and the ideal AND table.
module tb_and_truth_table_sequencer;

  localparam int H = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       c_in;
  logic       a_out, b_out, busy, done, pass;
  logic [3:0] result;
  logic [2:0] err_count;

  logic [3:0] gate_tt = 4'b1000;
  int         vectors = 0;
  int         miscompares = 0;

  and_truth_table_sequencer #(.HOLD_CYCLES(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .c_in     (c_in),
    .a_out    (a_out),
    .b_out    (b_out),
    .busy     (busy),
    .done     (done),
    .pass     (pass),
    .result   (result),
    .err_count(err_count)
  );

  // Gate model: entry {a,b} of the table is the gate output for that input pair.
  assign c_in = gate_tt[{a_out, b_out}];

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete run against table tt. pulse_at >= 0 re-pulses start inside the run;
  // keep_start holds start high throughout.
  task automatic run(input logic [3:0] tt, input int pulse_at, input bit keep_start);
    logic [3:0] want_res;
    int         want_err;
    gate_tt  = tt;
    want_res = tt;
    want_err = $countones(tt ^ 4'b1000);
    start = 1'b1;
    tick();
    start = keep_start;
    chk("start_busy", {7'd0, busy}, 8'd1);
    chk("start_done", {7'd0, done}, 8'd0);
    chk("start_pass", {7'd0, pass}, 8'd0);
    chk("start_result", {4'd0, result}, 8'd0);
    chk("start_err", {5'd0, err_count}, 8'd0);
    for (int k = 0; k < 4 * H; k++) begin
      chk("run_busy", {7'd0, busy}, 8'd1);
      chk("run_ab", {6'd0, a_out, b_out}, 8'(k / H));
      start = keep_start || (k == pulse_at);
      tick();
      start = keep_start;
    end
    chk("end_busy", {7'd0, busy}, 8'd0);
    chk("end_done", {7'd0, done}, 8'd1);
    chk("end_ab", {6'd0, a_out, b_out}, 8'd0);
    chk("end_result", {4'd0, result}, {4'd0, want_res});
    chk("end_err", {5'd0, err_count}, 8'(want_err));
    chk("end_pass", {7'd0, pass}, 8'(want_err == 0));
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    #12;
    chk("rst_busy", {7'd0, busy}, 8'd0);
    chk("rst_done", {7'd0, done}, 8'd0);
    chk("rst_ab", {6'd0, a_out, b_out}, 8'd0);
    chk("rst_result", {4'd0, result}, 8'd0);
    rst = 1'b0;
    tick();
    tick();
    chk("idle_busy", {7'd0, busy}, 8'd0);

    // Directed gates: AND, tied 0, tied 1, OR.
    run(4'b1000, -1, 1'b0);
    tick();
    chk("done_hold", {7'd0, done}, 8'd1);
    chk("done_hold_res", {4'd0, result}, 8'h08);
    run(4'b0000, -1, 1'b0);
    run(4'b1111, -1, 1'b0);
    run(4'b1110, -1, 1'b0);

    // Start re-pulsed mid-run is ignored.
    run(4'b1000, 4, 1'b0);
    tick();
    chk("single_done", {7'd0, done}, 8'd1);

    // From DONE with pass=1, restart with the gate stuck low.
    run(4'b0000, -1, 1'b0);

    // Start held high: back-to-back runs with one DONE cycle between.
    run(4'b1000, -1, 1'b1);
    run(4'b1000, -1, 1'b0);

    // Mid-run asynchronous reset.
    gate_tt = 4'b1111;
    start = 1'b1;
    tick();
    start = 1'b0;
    for (int k = 0; k < 9; k++) tick();
    chk("pre_rst_result", {4'd0, result}, 8'h03);
    rst = 1'b1;
    #1;
    chk("arst_busy", {7'd0, busy}, 8'd0);
    chk("arst_ab", {6'd0, a_out, b_out}, 8'd0);
    chk("arst_result", {4'd0, result}, 8'd0);
    chk("arst_err", {5'd0, err_count}, 8'd0);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3 * H; k++) tick();
    chk("post_rst_busy", {7'd0, busy}, 8'd0);
    chk("post_rst_done", {7'd0, done}, 8'd0);
    chk("post_rst_result", {4'd0, result}, 8'd0);

    // Random gate tables.
    for (int r = 0; r < 12; r++) begin
      run(4'($urandom_range(0, 15)), ((r % 3) == 0) ? int'($urandom_range(0, 4 * H - 1)) : -1,
          1'b0);
      if ((r % 2) == 1) tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/and_truth_table_sequencer.md
Name: and_truth_table_sequencer

Overview:
- Self-checking stimulus stage for the two-input AND gate block.
- Drives the gate's a/b inputs through all four input combinations in order 00, 01, 10, 11. Holds each vector for a fixed settle time, then samples the gate output c.
- Compares each sample against the expected a&b and reports per-vector results, mismatch count and pass/fail.
- Sits directly upstream of the gate (feeds a, b) and consumes its output c; used on board bring-up and in benches.

Parameters:
- HOLD_CYCLES, 4, clock cycles each vector is held before c_in is sampled; legal range 2..255.

Ports:
- clk  input  1  system clock, rising-edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  run request, sampled on rising clk edge.
- c_in  input  1  output of the AND gate under test.
- a_out  output  1  gate input a (registered).
- b_out  output  1  gate input b (registered).
- busy  output  1  high while a run is in progress.
- done  output  1  high after a run completes; held until next accepted start or reset.
- pass  output  1  high when done=1 and err_count=0.
- result  output  4  captured c_in per vector; bit i = sample for vector i = {a,b}.
- err_count  output  3  number of mismatching vectors, 0..4.

Behaviour:
- Reset:
  - Asynchronous and active-high: one clock, rst asynchronous active-high.
  - Assertion forces state=IDLE immediately and sets a_out=0, b_out=0, busy=0, done=0, pass=0, result=4'b0000, err_count=0, vec=0, hold counter=0.
  - Applies mid-run too. After reset, no further sampling occurs.
- States: IDLE, APPLY, DONE. All outputs are registered.
- IDLE:
  - start=1 at an edge moves to APPLY; busy=1, vec=0, a_out=0, b_out=0, hold_cnt=0.
  - result and err_count clear on the same edge.
- APPLY:
  - a_out=vec[1], b_out=vec[0]; hold_cnt increments each edge.
  - At the edge where hold_cnt==HOLD_CYCLES-1:
    - result[vec] <= c_in.
    - If c_in != (vec[1]&vec[0]), err_count increments.
    - hold_cnt resets to 0.
    - If vec<3: vec increments and a_out/b_out update to the next vector on the same edge.
    - If vec==3: next state is DONE.
- Timing:
  - Each vector occupies exactly HOLD_CYCLES cycles.
  - busy is high for 4*HOLD_CYCLES cycles, starting the cycle after start is accepted.
- DONE:
  - busy=0, done=1, pass=(err_count==0). a_out/b_out return to 0.
  - result and err_count are held stable.
  - start=1 re-enters APPLY exactly as from IDLE: done and pass drop and results clear on that edge.
- Start handling:
  - start while busy=1 is ignored, with no effect on vec, hold_cnt or results.
  - start held high continuously produces back-to-back runs: one cycle in DONE, then restart.
- err_count saturates naturally at 4; no wrap is possible with 4 vectors.
- c_in is sampled synchronously. The gate is combinational, so HOLD_CYCLES>=2 guarantees a_out/b_out have been stable at least one full cycle before sampling.

Test Plan:
- Ideal AND gate on c_in, HOLD_CYCLES=4, pulse start -> busy high 16 cycles. a_out/b_out step 00,01,10,11 every 4 cycles. Then done=1, result=4'b1000, err_count=0, pass=1.
- c_in tied 0 -> result=4'b0000, err_count=1, pass=0. c_in tied 1 -> result=4'b1111, err_count=3, pass=0.
- OR gate substituted for AND -> result=4'b1110, err_count=2, pass=0.
- Pulse start again at cycle 5 of a run -> vector timing unchanged, run still ends at cycle 16, single done.
- Assert rst at cycle 9 of a run -> on that edge busy=0, a_out=b_out=0, result=0, err_count=0. After release, state is IDLE until next start.
- From DONE with pass=1, pulse start with c_in tied 0 -> done/pass drop, results cleared. Completion gives result=0000, err_count=1, pass=0.
